// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a power-of-two word FIFO feeding a start/data/parity/stop
// serializer. The line and baud pulse are registered, so both trail the FSM state by one cycle.
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 434,
    parameter int BITS_N       = 8,
    parameter int PARITY_TYPE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [BITS_N-1:0]             data_tx,
    input  logic                          valid,
    output logic                          ready,
    output logic                          uart_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          baud_trigger
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(BITS_N);

    typedef enum logic [2:0] {IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT} state_t;
    state_t state_q, state_d;

    logic [BITS_N-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q, count_d;
    logic [CW-1:0]     cnt_q;
    logic [BW-1:0]     bit_idx_q;
    logic              stop_idx_q;
    logic [BITS_N-1:0] shreg_q;
    logic              par_q, par_d;
    logic              uart_q, uart_d, baud_q, baud_d;
    logic              push, pop, empty, tick, last_data, last_stop;
    logic [BITS_N-1:0] head;

    assign ready        = (count_q != (AW+1)'(FIFO_DEPTH));
    assign empty        = (count_q == '0);
    assign push         = valid && ready && !rst;
    assign head         = mem_q[rd_ptr_q];
    assign tick         = (state_q != IDLE) && (cnt_q == CW'(CLKS_PER_BIT-1));
    assign last_data    = (bit_idx_q == BW'(BITS_N-1));
    assign last_stop    = (stop_idx_q == 1'(STOP_BITS-1));
    assign pop          = !empty && ((state_q == IDLE) || (state_q == STOP_BIT && tick && last_stop));
    assign par_d        = (PARITY_TYPE == 1) ? ~^head : ^head;
    assign uart_out     = uart_q;
    assign baud_trigger = baud_q;
    assign busy         = (state_q != IDLE) || !empty;
    assign fifo_count   = count_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + (AW+1)'(1);
        else if (pop && !push) count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_tx;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (!empty) state_d = START_BIT;
            START_BIT:  if (tick) state_d = DATA_BITS;
            DATA_BITS:  if (tick && last_data) state_d = (PARITY_TYPE != 0) ? PARITY_BIT : STOP_BIT;
            PARITY_BIT: if (tick) state_d = STOP_BIT;
            STOP_BIT:   if (tick && last_stop) state_d = empty ? IDLE : START_BIT;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        uart_d = 1'b1;
        case (state_q)
            START_BIT:  uart_d = 1'b0;
            DATA_BITS:  uart_d = shreg_q[0];
            PARITY_BIT: uart_d = par_q;
            default:    uart_d = 1'b1;
        endcase
        baud_d = tick;
    end

    // Word and parity are latched at pop so later FIFO writes cannot disturb a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            uart_q     <= 1'b1;
            baud_q     <= 1'b0;
        end else begin
            uart_q <= uart_d;
            baud_q <= baud_d;
            if (state_q == IDLE || tick) cnt_q <= '0;
            else                         cnt_q <= cnt_q + CW'(1);
            if (pop) begin
                shreg_q    <= head;
                par_q      <= par_d;
                bit_idx_q  <= '0;
                stop_idx_q <= 1'b0;
            end else begin
                if (state_q == DATA_BITS && tick) begin
                    shreg_q   <= shreg_q >> 1;
                    bit_idx_q <= bit_idx_q + BW'(1);
                end
                if (state_q == STOP_BIT && tick) stop_idx_q <= !last_stop;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: a reference RX monitor scores frames against a queue of
// accepted words; a second instance checks odd parity, two stop bits and baud pulse timing.
module tb_uart_tx_buffered;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       ready_a, uart_a, busy_a, baud_a;
    logic       ready_b, uart_b, busy_b, baud_b;
    logic [2:0] cnt_a, cnt_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frames = 0;
    int baud_cnt = 0;
    int rx_ph = -1;
    logic [10:0] rx_bits;
    bit rst_seen = 1'b0;
    logic [7:0] exp_q[$];
    int starts[$];

    logic [7:0] v6_w [10] = '{8'h00, 8'hFF, 8'h3C, 8'hC3, 8'h5A, 8'h81, 8'h7E, 8'h01, 8'h80, 8'h96};
    int         v6_g [10] = '{0, 0, 0, 0, 0, 0, 50, 3, 90, 0};

    always #5 clk = ~clk;

    uart_tx_buffered #(.CLKS_PER_BIT(4), .BITS_N(8), .PARITY_TYPE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .data_tx(data_a), .valid(valid_a), .ready(ready_a),
        .uart_out(uart_a), .busy(busy_a), .fifo_count(cnt_a), .baud_trigger(baud_a));

    uart_tx_buffered #(.CLKS_PER_BIT(4), .BITS_N(8), .PARITY_TYPE(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .data_tx(data_b), .valid(valid_b), .ready(ready_b),
        .uart_out(uart_b), .busy(busy_b), .fifo_count(cnt_b), .baud_trigger(baud_b));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rst_seen <= rst;
    end

    // Reference receiver: samples mid-bit on the line of instance A, 8E1 at 4 clocks/bit.
    always @(negedge clk) begin
        logic [7:0] w;
        if (baud_a === 1'b1) baud_cnt++;
        if (rst_seen) rx_ph = -1;
        else if (rx_ph < 0) begin
            if (uart_a === 1'b0) begin
                rx_ph = 0;
                starts.push_back(cyc);
            end
        end else rx_ph++;
        if (rx_ph >= 0 && rx_ph % 4 == 2) rx_bits[rx_ph/4] = uart_a;
        if (rx_ph == 42) begin
            frames++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL frame: unexpected frame bits %b with nothing queued", rx_bits);
            end else begin
                w = exp_q.pop_front();
                if (rx_bits[0] !== 1'b0 || rx_bits[8:1] !== w || rx_bits[9] !== ^w || rx_bits[10] !== 1'b1) begin
                    errors++;
                    $display("FAIL frame: got bits %b expected word %02h parity %b", rx_bits, w, ^w);
                end
            end
        end
        if (rx_ph == 43) rx_ph = -1;
    end

    task automatic send(input logic [7:0] w, input bit exp_acc);
        data_a  = w;
        valid_a = 1'b1;
        chk("ready", ready_a, exp_acc);
        if (ready_a) exp_q.push_back(w);
        @(negedge clk);
        valid_a = 1'b0;
    endtask

    task automatic send_retry(input logic [7:0] w);
        int n = 0;
        while (!ready_a && n < 2000) begin
            @(negedge clk);
            n++;
        end
        send(w, 1'b1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy_a || rx_ph >= 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy %b rx_ph %0d", busy_a, rx_ph);
        end
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b0, f0;
        logic exp_bit;
        rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0; data_a = '0; data_b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_uart", uart_a, 1'b1);
        chk("rst_ready", ready_a, 1'b1);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_count", cnt_a, 3'd0);
        chk("rst_baud", baud_a, 1'b0);
        chk("rst_uart_b", uart_b, 1'b1);

        // V1: even parity 0xA5, start bit low two edges after the push
        b0 = baud_cnt;
        send(8'hA5, 1'b1);
        chk("v1_count1", cnt_a, 3'd1);
        chk("v1_busy", busy_a, 1'b1);
        chk("v1_line_k", uart_a, 1'b1);
        @(negedge clk);
        chk("v1_line_k1", uart_a, 1'b1);
        chk("v1_count0", cnt_a, 3'd0);
        @(negedge clk);
        chk("v1_start_k2", uart_a, 1'b0);
        wait_idle();
        chk("v1_baud_pulses", baud_cnt - b0, 11);
        chk("v1_idle_busy", busy_a, 1'b0);
        chk("v1_idle_baud", baud_a, 1'b0);

        // V2: odd parity, two stop bits, 0x01 on instance B
        data_b = 8'h01; valid_b = 1'b1;
        @(negedge clk);
        valid_b = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            if (c < 4)       exp_bit = 1'b0;
            else if (c < 8)  exp_bit = 1'b1;
            else if (c < 36) exp_bit = 1'b0;
            else if (c < 40) exp_bit = 1'b0;
            else             exp_bit = 1'b1;
            if (c % 4 == 2) chk($sformatf("v2_line_c%0d", c), uart_b, exp_bit);
            chk($sformatf("v2_baud_c%0d", c), baud_b, (c % 4 == 3));
        end
        @(negedge clk);
        chk("v2_busy_end", busy_b, 1'b0);
        chk("v2_line_end", uart_b, 1'b1);

        // V3: five back-to-back pushes, sixth rejected, contiguous frames
        starts.delete();
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        send(8'h33, 1'b1);
        send(8'h44, 1'b1);
        send(8'h55, 1'b1);
        send(8'h66, 1'b0);
        chk("v3_count_full", cnt_a, 3'd4);
        wait_idle();
        chk("v3_frames", starts.size(), 5);
        for (int i = 1; i < 5 && i < starts.size(); i++)
            chk($sformatf("v3_gap%0d", i), starts[i] - starts[i-1], 44);

        // V4: push exactly on the pop cycle of a full FIFO is rejected
        send(8'hA0, 1'b1);
        send(8'hA1, 1'b1);
        send(8'hA2, 1'b1);
        send(8'hA3, 1'b1);
        send(8'hA4, 1'b1);
        repeat (40) @(negedge clk);
        send(8'h99, 1'b0);
        chk("v4_count_after_pop", cnt_a, 3'd3);
        send(8'h9A, 1'b1);
        chk("v4_count_refill", cnt_a, 3'd4);
        wait_idle();

        // V5: reset mid-frame drops the frame and the queue; valid during reset ignored
        f0 = frames;
        send(8'hB0, 1'b1);
        send(8'hB1, 1'b1);
        send(8'hB2, 1'b1);
        chk("v5_queued", cnt_a, 3'd2);
        repeat (8) @(negedge clk);
        rst = 1'b1; data_a = 8'hEE; valid_a = 1'b1;
        @(negedge clk);
        chk("v5_uart", uart_a, 1'b1);
        chk("v5_count", cnt_a, 3'd0);
        chk("v5_busy", busy_a, 1'b0);
        chk("v5_ready", ready_a, 1'b1);
        chk("v5_baud", baud_a, 1'b0);
        rst = 1'b0; valid_a = 1'b0;
        exp_q.delete();
        repeat (100) @(negedge clk);
        chk("v5_no_frames", frames - f0, 0);
        chk("v5_line_idle", uart_a, 1'b1);
        chk("v5_count_idle", cnt_a, 3'd0);

        // V6: ten words with irregular gaps, pointers wrap several times
        for (int i = 0; i < 10; i++) begin
            repeat (v6_g[i]) @(negedge clk);
            send_retry(v6_w[i]);
        end
        wait_idle();
        chk("v6_all_received", exp_q.size(), 0);
        chk("v6_count_end", cnt_a, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
- REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (>=2).
- REQ-002 SHALL have parameter BITS_N, default 8, data bits per frame (legal 5..9).
- REQ-003 SHALL have parameter PARITY_TYPE, default 0: 0 none, 1 odd, 2 even.
- REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame (legal 1 or 2).
- REQ-005 SHALL have parameter FIFO_DEPTH, default 8, transmit FIFO entries (power of 2, >=2).
- REQ-006 SHALL have port clk  input  1  clock; all logic on rising edge.
- REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
- REQ-008 SHALL have port data_tx  input  BITS_N  word to enqueue.
- REQ-009 SHALL have port valid  input  1  data_tx valid this cycle.
- REQ-010 SHALL have port ready  output  1  FIFO not full, word accepted when valid&&ready.
- REQ-011 SHALL have port uart_out  output  1  serial TX line, idle high.
- REQ-012 SHALL have port busy  output  1  frame in progress or FIFO non-empty.
- REQ-013 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  words currently queued.
- REQ-014 SHALL have port baud_trigger  output  1  one-cycle pulse in last cycle of each transmitted bit period.

Function
- REQ-015 Push when valid&&ready; fifo_count increments next cycle; write while full (ready=0) SHALL be ignored, no state change.
- REQ-016 ready SHALL be combinational: (fifo_count != FIFO_DEPTH).
- REQ-017 FSM states SHALL be IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT.
- REQ-018 IDLE with FIFO non-empty: pop head into shift register, compute parity from popped word, enter START_BIT next cycle.
- REQ-019 Latency: word pushed into empty FIFO at edge k SHALL drive uart_out low from edge k+2.
- REQ-020 Each bit (start, data, parity, each stop) SHALL last exactly CLKS_PER_BIT cycles; cycle counter resets to 0 on every baud_trigger.
- REQ-021 Data SHALL be sent LSB first, BITS_N bits; PARITY_BIT skipped when PARITY_TYPE=0.
- REQ-022 Parity bit: odd -> XNOR-reduce of word; even -> XOR-reduce; value fixed at pop time, not recomputed mid-frame.
- REQ-023 STOP_BIT SHALL hold uart_out high for STOP_BITS*CLKS_PER_BIT cycles.
- REQ-024 At end of STOP_BIT: FIFO non-empty -> pop and go directly to START_BIT (zero idle cycles between frames); else IDLE.
- REQ-025 Simultaneous push and pop SHALL both occur; fifo_count unchanged; push into full FIFO on pop cycle still rejected (ready=0).
- REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; order preserved across wrap.
- REQ-027 uart_out: 1 in IDLE/STOP_BIT, 0 in START_BIT, current data bit in DATA_BITS, parity in PARITY_BIT; SHALL be registered (glitch-free).
- REQ-028 baud_trigger SHALL be 0 in IDLE.
- REQ-029 busy = (state!=IDLE) || (fifo_count!=0).

Reset
- REQ-030 On rst: state IDLE, FIFO emptied (fifo_count=0), counters 0, uart_out=1 from next edge, busy=0, ready=1, baud_trigger=0.
- REQ-031 rst mid-frame SHALL abort frame and discard all queued words; valid during rst SHALL be ignored.

Verification (CLKS_PER_BIT=4, BITS_N=8, FIFO_DEPTH=4 unless stated)
- V1 PARITY_TYPE=2, push 0xA5 -> line 0,1,0,1,0,0,1,0,1,0(parity),1 each 4 cycles (44 cycles), start low 2 edges after push.
- V2 PARITY_TYPE=1, STOP_BITS=2, push 0x01 -> parity 0, stop high 8 cycles, frame 48 cycles.
- V3 push 0x11,0x22,0x33,0x44,0x55 back-to-back -> first pops immediately, 0x55 accepted (4 queued), sixth push rejected; frames contiguous, no gap, order preserved.
- V4 FIFO full, push during pop cycle -> rejected, fifo_count stays 3 after pop; next push accepted.
- V5 rst asserted 10 cycles into frame with 2 queued -> uart_out=1, fifo_count=0, busy=0 next cycle; no further frames.
- V6 10 frames through depth-4 FIFO with random fill -> pointer wrap, all words received in order (reference UART RX model).
